// File: rtl/hwag_sync_fsm.sv
// Crank-wheel synchronisation FSM: finds the missing-tooth gap, verifies one revolution,
// then tracks the tooth index and flags loss, revolution and stall events.
module hwag_sync_fsm #(
  parameter int unsigned W     = 24,
  parameter int unsigned TEETH = 60,
  parameter int unsigned LOST  = 2,
  parameter int unsigned CW    = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ena_i,
  input  logic          cap_stb_i,
  input  logic [W-1:0]  cap0_i,
  input  logic [W-1:0]  cap1_i,
  input  logic [W-1:0]  cap2_i,
  input  logic          in_range_i,
  input  logic          pcnt_ovf_i,
  output logic [2:0]    state_o,
  output logic          synced_o,
  output logic [CW-1:0] tooth_cnt_o,
  output logic          sync_stb_o,
  output logic          lost_stb_o,
  output logic          rev_stb_o,
  output logic          stall_stb_o,
  output logic          pcap_clr_o
);

  localparam int unsigned WAIT_W = 2;
  localparam logic [CW-1:0] LAST_TOOTH = CW'(TEETH - LOST - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT3  = 3'd1,
    ST_SEARCH = 3'd2,
    ST_VERIFY = 3'd3,
    ST_SYNC   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     tooth_q, tooth_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              synced_q, synced_d;
  logic              sync_stb_q, sync_stb_d;
  logic              lost_stb_q, lost_stb_d;
  logic              rev_stb_q, rev_stb_d;
  logic              stall_stb_q, stall_stb_d;
  logic              pcap_clr_q, pcap_clr_d;

  // Doubled periods compared one bit wider so large captures cannot wrap.
  logic [W:0] cap0_x_c, cap1_x2_c, cap2_x2_c;
  logic       gap_cond_c, norm_cond_c;

  always_comb begin
    cap0_x_c    = {1'b0, cap0_i};
    cap1_x2_c   = {cap1_i, 1'b0};
    cap2_x2_c   = {cap2_i, 1'b0};
    gap_cond_c  = (cap0_x_c >= cap1_x2_c) && (cap0_x_c >= cap2_x2_c);
    norm_cond_c = !gap_cond_c && in_range_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      tooth_q     <= '0;
      wait_q      <= '0;
      synced_q    <= 1'b0;
      sync_stb_q  <= 1'b0;
      lost_stb_q  <= 1'b0;
      rev_stb_q   <= 1'b0;
      stall_stb_q <= 1'b0;
      pcap_clr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tooth_q     <= tooth_d;
      wait_q      <= wait_d;
      synced_q    <= synced_d;
      sync_stb_q  <= sync_stb_d;
      lost_stb_q  <= lost_stb_d;
      rev_stb_q   <= rev_stb_d;
      stall_stb_q <= stall_stb_d;
      pcap_clr_q  <= pcap_clr_d;
    end
  end

  // Next state: disable beats stall, stall beats a capture in the same cycle.
  always_comb begin
    state_d     = state_q;
    tooth_d     = tooth_q;
    wait_d      = wait_q;
    sync_stb_d  = 1'b0;
    lost_stb_d  = 1'b0;
    rev_stb_d   = 1'b0;
    stall_stb_d = 1'b0;
    pcap_clr_d  = 1'b0;

    if (!ena_i) begin
      state_d = ST_IDLE;
      tooth_d = '0;
      wait_d  = '0;
    end else if (pcnt_ovf_i && (state_q != ST_IDLE)) begin
      state_d     = ST_WAIT3;
      tooth_d     = '0;
      wait_d      = '0;
      stall_stb_d = 1'b1;
      pcap_clr_d  = 1'b1;
      lost_stb_d  = synced_q;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT3;
          tooth_d = '0;
          wait_d  = '0;
        end
        ST_WAIT3: begin
          if (cap_stb_i) begin
            if (wait_q == WAIT_LAST) begin
              state_d = ST_SEARCH;
              wait_d  = '0;
            end else begin
              wait_d = wait_q + WAIT_W'(1);
            end
          end
        end
        ST_SEARCH: begin
          if (cap_stb_i && gap_cond_c) begin
            state_d = ST_VERIFY;
            tooth_d = '0;
          end
        end
        ST_VERIFY, ST_SYNC: begin
          if (cap_stb_i) begin
            if ((tooth_q < LAST_TOOTH) && norm_cond_c) begin
              tooth_d = tooth_q + CW'(1);
            end else if ((tooth_q == LAST_TOOTH) && gap_cond_c) begin
              state_d    = ST_SYNC;
              tooth_d    = '0;
              sync_stb_d = (state_q == ST_VERIFY);
              rev_stb_d  = (state_q == ST_SYNC);
            end else begin
              state_d    = ST_SEARCH;
              tooth_d    = '0;
              lost_stb_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          tooth_d = '0;
          wait_d  = '0;
        end
      endcase
    end

    synced_d = (state_d == ST_SYNC);
  end

  assign state_o     = state_q;
  assign synced_o    = synced_q;
  assign tooth_cnt_o = tooth_q;
  assign sync_stb_o  = sync_stb_q;
  assign lost_stb_o  = lost_stb_q;
  assign rev_stb_o   = rev_stb_q;
  assign stall_stb_o = stall_stb_q;
  assign pcap_clr_o  = pcap_clr_q;

endmodule
